// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S capture-to-RAM receiver
package i2s_pkg;

    localparam int          DEFAULT_BIT_DEPTH = 16;
    localparam logic [24:0] HEADER_SKIP_ADDR  = 25'h2C;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SKIP,
        RX_DATA,
        RX_PAD
    } rx_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RELEASE
    } wr_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - synchronous sample FIFO between I2S capture and the RAM write port
module i2s_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the same cycle frees a slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S ADC capture into a RAM region through a request/acknowledge bridge
// Optional macro I2S_RX_HEX_DEBUG_EN drives hex_out_* with write-address nibbles.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int BIT_DEPTH  = DEFAULT_BIT_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        I2S_SCLK,
    input  logic        I2S_LRCLK,
    input  logic        I2S_DOUT,
    input  logic        I2S_enable,
    input  logic        ADDR_load,
    input  logic [24:0] ADDR_start,
    input  logic [24:0] ADDR_end,
    output logic [24:0] ADDR_PRGM,
    output logic [15:0] WRdata_PRGM,
    output logic        WRen,
    input  logic        avalon_bridge_acknowledge,
    output logic        rx_active,
    output logic        rx_done,
    output logic        rx_overflow,
    output logic [3:0]  hex_out_5,
    output logic [3:0]  hex_out_4,
    output logic [3:0]  hex_out_3,
    output logic [3:0]  hex_out_2,
    output logic [3:0]  hex_out_1,
    output logic [3:0]  hex_out_0
);

    localparam int CNT_W = $clog2(BIT_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_DEPTH - 1);

    logic [1:0] sclk_sync_q, lrclk_sync_q, dout_sync_q;
    logic       sclk_prev_q, lr_prev_q;
    logic       sclk_rise, lr_change, lr_fall, dout_bit;

    rx_state_t              rx_state_q, rx_state_d;
    logic [BIT_DEPTH-2:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_DEPTH-1:0]   push_word;
    logic                   fifo_push, frame_abort;

    wr_state_t   wr_state_q, wr_state_d;
    logic [24:0] addr_q, addr_d;
    logic [15:0] wrdata_q, wrdata_d;
    logic        fifo_pop, done_set, load_accept;
    logic        rx_done_q, rx_overflow_q, overflow_set;

    logic [BIT_DEPTH-1:0] fifo_head;
    logic [15:0]          head16;
    logic                 fifo_full, fifo_empty;

    always_ff @(posedge clk50) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            dout_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            lr_prev_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], I2S_SCLK};
            lrclk_sync_q <= {lrclk_sync_q[0], I2S_LRCLK};
            dout_sync_q  <= {dout_sync_q[0], I2S_DOUT};
            sclk_prev_q  <= sclk_sync_q[1];
            if (sclk_rise) begin
                lr_prev_q <= lrclk_sync_q[1];
            end
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign lr_change = sclk_rise & (lrclk_sync_q[1] != lr_prev_q);
    assign lr_fall   = sclk_rise & lr_prev_q & ~lrclk_sync_q[1];
    assign dout_bit  = dout_sync_q[1];
    assign push_word = {shift_q, dout_bit};

    always_ff @(posedge clk50) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        fifo_push   = 1'b0;
        frame_abort = 1'b0;
        if (!I2S_enable || rx_done_q || done_set) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (lr_fall) rx_state_d = RX_SKIP;
                end
                RX_SKIP: begin
                    if (sclk_rise) begin
                        rx_state_d = RX_DATA;
                        cnt_d      = '0;
                    end
                end
                RX_DATA: begin
                    if (lr_change) begin
                        frame_abort = 1'b1;
                        rx_state_d  = RX_SKIP;
                    end else if (sclk_rise) begin
                        shift_d = push_word[BIT_DEPTH-2:0];
                        if (cnt_q == LAST_BIT) begin
                            fifo_push  = 1'b1;
                            rx_state_d = RX_PAD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RX_PAD: begin
                    if (lr_change) rx_state_d = RX_SKIP;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    i2s_rx_fifo #(
        .WIDTH (BIT_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk50),
        .reset_i     (reset),
        .flush_i     (done_set),
        .push_i      (fifo_push),
        .push_data_i (push_word),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // RAM words are 16 bits; samples are left-justified into them.
    generate
        if (BIT_DEPTH >= 16) begin : g_head_trunc
            assign head16 = fifo_head[BIT_DEPTH-1 -: 16];
        end else begin : g_head_pad
            assign head16 = {fifo_head, {(16 - BIT_DEPTH){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            addr_q     <= HEADER_SKIP_ADDR;
            wrdata_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        fifo_pop    = 1'b0;
        done_set    = 1'b0;
        load_accept = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (ADDR_load) begin
                    addr_d      = ADDR_start;
                    load_accept = 1'b1;
                end
                if (!fifo_empty) begin
                    wrdata_d   = head16;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (avalon_bridge_acknowledge) begin
                    fifo_pop   = 1'b1;
                    addr_d     = addr_q + 25'd1;
                    done_set   = (addr_d == ADDR_end);
                    wr_state_d = W_RELEASE;
                end
            end
            W_RELEASE: begin
                if (!avalon_bridge_acknowledge) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign overflow_set = frame_abort | (fifo_push & fifo_full & ~fifo_pop);

    always_ff @(posedge clk50) begin
        if (reset) begin
            rx_done_q     <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            if (load_accept) begin
                rx_done_q     <= 1'b0;
                rx_overflow_q <= 1'b0;
            end
            if (done_set)     rx_done_q     <= 1'b1;
            if (overflow_set) rx_overflow_q <= 1'b1;
        end
    end

    assign ADDR_PRGM   = addr_q;
    assign WRdata_PRGM = wrdata_q;
    assign WRen        = (wr_state_q == W_REQ);
    assign rx_active   = (rx_state_q != RX_IDLE);
    assign rx_done     = rx_done_q;
    assign rx_overflow = rx_overflow_q;

`ifdef I2S_RX_HEX_DEBUG_EN
    assign hex_out_5 = addr_q[23:20];
    assign hex_out_4 = addr_q[19:16];
    assign hex_out_3 = addr_q[15:12];
    assign hex_out_2 = addr_q[11:8];
    assign hex_out_1 = addr_q[7:4];
    assign hex_out_0 = addr_q[3:0];
`else
    assign hex_out_5 = 4'h0;
    assign hex_out_4 = 4'h0;
    assign hex_out_3 = 4'h0;
    assign hex_out_2 = 4'h0;
    assign hex_out_1 = 4'h0;
    assign hex_out_0 = 4'h0;
`endif

endmodule
